// File: rtl/dot_pos_display_if.sv
// rtl/dot_pos_display_if.sv - dot vector in, position/flags and 2-digit display out
interface dot_pos_display_if;
    logic [15:0] dataIn;
    logic [6:0]  seg;
    logic [1:0]  an;
    logic [3:0]  pos;
    logic        valid;
    logic        moved;

    modport master (
        output dataIn,
        input  seg, an, pos, valid, moved
    );

    modport slave (
        input  dataIn,
        output seg, an, pos, valid, moved
    );
endinterface

// File: rtl/dot_pos_display.sv
// rtl/dot_pos_display.sv - one-hot dot position decoder with 2-digit multiplexed display
// Optional: DOT_POS_DISPLAY_BLANK_LEAD_EN blanks the tens digit for positions below 10.
module dot_pos_display #(
    parameter int SCAN_COUNT = 50000
) (
    input  logic            clk,
    input  logic            rst,
    dot_pos_display_if.slave bus
);
    localparam int CW = (SCAN_COUNT > 2) ? $clog2(SCAN_COUNT) : 1;
    localparam logic [CW-1:0] TERM = CW'(SCAN_COUNT - 1);

    localparam logic [6:0] SEG_DASH  = 7'b1111110;
    localparam logic [6:0] SEG_BLANK = 7'b1111111;

    logic [15:0]   data_reg_q, data_reg_d;
    logic [3:0]    pos_q, pos_d;
    logic          valid_q, valid_d;
    logic          moved_q, moved_d;
    logic [CW-1:0] scan_cnt_q, scan_cnt_d;
    logic          dig_sel_q, dig_sel_d;

    logic [3:0]    hit_pos;
    logic          one_hot;
    logic [3:0]    units;
    logic [6:0]    seg_c;

    function automatic logic [6:0] seg_of(input logic [3:0] d);
        case (d)
            4'd0:    seg_of = 7'b0000001;
            4'd1:    seg_of = 7'b1001111;
            4'd2:    seg_of = 7'b0010010;
            4'd3:    seg_of = 7'b0000110;
            4'd4:    seg_of = 7'b1001100;
            4'd5:    seg_of = 7'b0100100;
            4'd6:    seg_of = 7'b0100000;
            4'd7:    seg_of = 7'b0001111;
            4'd8:    seg_of = 7'b0000000;
            4'd9:    seg_of = 7'b0000100;
            default: seg_of = SEG_BLANK;
        endcase
    endfunction

    always_comb begin
        data_reg_d = bus.dataIn;
        one_hot    = ($countones(data_reg_q) == 1);
        hit_pos    = 4'd0;
        for (int i = 0; i < 16; i++) begin
            if (data_reg_q[i]) hit_pos = 4'(15 - i);
        end

        // Position holds across invalid samples; moved fires only on a valid landing.
        valid_d = one_hot;
        pos_d   = one_hot ? hit_pos : pos_q;
        moved_d = one_hot && (!valid_q || (hit_pos != pos_q));

        if (scan_cnt_q == TERM) begin
            scan_cnt_d = '0;
            dig_sel_d  = ~dig_sel_q;
        end else begin
            scan_cnt_d = scan_cnt_q + 1'b1;
            dig_sel_d  = dig_sel_q;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            data_reg_q <= '0;
            pos_q      <= '0;
            valid_q    <= 1'b0;
            moved_q    <= 1'b0;
            scan_cnt_q <= '0;
            dig_sel_q  <= 1'b0;
        end else begin
            data_reg_q <= data_reg_d;
            pos_q      <= pos_d;
            valid_q    <= valid_d;
            moved_q    <= moved_d;
            scan_cnt_q <= scan_cnt_d;
            dig_sel_q  <= dig_sel_d;
        end
    end

    always_comb begin
        units = (pos_q >= 4'd10) ? (pos_q - 4'd10) : pos_q;
        seg_c = SEG_DASH;
        if (valid_q) begin
            if (!dig_sel_q) begin
                seg_c = seg_of(units);
            end else if (pos_q >= 4'd10) begin
                seg_c = seg_of(4'd1);
            end else begin
`ifdef DOT_POS_DISPLAY_BLANK_LEAD_EN
                seg_c = SEG_BLANK;
`else
                seg_c = seg_of(4'd0);
`endif
            end
        end
    end

    assign bus.seg   = seg_c;
    assign bus.an    = dig_sel_q ? 2'b01 : 2'b10;
    assign bus.pos   = pos_q;
    assign bus.valid = valid_q;
    assign bus.moved = moved_q;
endmodule

// File: doc/dot_pos_display.md
DOT_POS_DISPLAY -- requirements
Module: dot_pos_display

Interface
REQ-001 SHALL have parameter SCAN_COUNT, default 50000, meaning clock cycles each digit stays enabled (legal 2..2^20).
REQ-002 SHALL have port clk  input  1  sole clock, all state updates on rising edge.
REQ-003 SHALL have port rst  input  1  asynchronous active-high reset.
REQ-004 SHALL have port dataIn  input  16  dot vector from upstream sliding-dot stage; bit15 = leftmost LED.
REQ-005 SHALL have port seg  output  7  active-low segments, seg[6:0] = a,b,c,d,e,f,g.
REQ-006 SHALL have port an  output  2  active-low digit enables; an[1] = tens, an[0] = units.
REQ-007 SHALL have port pos  output  4  registered dot position, 0 = bit15 set, 15 = bit0 set.
REQ-008 SHALL have port valid  output  1  registered flag, dataIn was exactly one-hot.
REQ-009 SHALL have port moved  output  1  one-cycle pulse on position change.

Function
REQ-010 SHALL register dataIn into dataReg every cycle (stage 1).
REQ-011 SHALL compute valid and pos from dataReg and register them on the next edge (stage 2); dataIn at edge k appears on pos/valid after edge k+1.
REQ-012 SHALL set valid=1 only when dataReg has exactly one bit set; zero and multi-hot both give valid=0.
REQ-013 SHALL set pos = 15 - index of set bit when valid=1, and SHALL hold the previous pos when valid=0.
REQ-014 SHALL assert moved for exactly one cycle, coincident with the stage-2 update, when the new valid=1 and either the previous valid=0 or the new pos differs from the previous pos.
REQ-015 SHALL hold moved=0 while the same valid position persists and while valid=0.
REQ-016 SHALL run the scan counter 0..SCAN_COUNT-1.
- At terminal count: counter returns to 0 and digit select toggles.
- Wrap-around is continuous and independent of dataIn.
REQ-017 SHALL drive an from digit select: select 0 -> an=2'b10 (units), select 1 -> an=2'b01 (tens); an=2'b11 never occurs outside reset.
REQ-018 SHALL use tens digit = 1 if pos >= 10 else 0, and units digit = pos mod 10.
REQ-019 SHALL encode digits active-low as:
- 0=0000001, 1=1001111, 2=0010010, 3=0000110, 4=1001100
- 5=0100100, 6=0100000, 7=0001111, 8=0000000, 9=0000100
- dash=1111110, blank=1111111
REQ-020 SHALL show dash on both digits whenever valid=0.
REQ-021 SHALL derive seg and an only from registered digit select, pos and valid, so they carry no combinational path from dataIn.

Reset
REQ-022 SHALL, while rst=1 and without waiting for a clock edge, force:
- dataReg=0, pos=0, valid=0, moved=0
- scan counter=0, digit select=0
- an=2'b10, seg=1111110
REQ-023 SHALL restart the pipeline and scan from these values on the first rising edge after rst deasserts; rst asserted mid-scan or mid-pulse aborts both immediately.

Configuration
REQ-024 SHALL, with macro DOT_POS_DISPLAY_BLANK_LEAD_EN defined, drive seg=1111111 (blank) in the tens slot when valid=1 and pos < 10.
REQ-025 SHALL, without DOT_POS_DISPLAY_BLANK_LEAD_EN, show 0 (0000001) in the tens slot when valid=1 and pos < 10.
- Timing, an and all other behaviour are identical in both builds.

Verification (SCAN_COUNT=4)
REQ-026 SHALL test reset: assert rst mid-scan with no clock edge -> an=2'b10, seg=1111110, pos=0, valid=0, moved=0 immediately.
REQ-027 SHALL test first dot: dataIn=16'h8000 after reset -> valid=1 and pos=0 two edges later; moved high exactly one cycle; units slot seg=0000001.
REQ-028 SHALL test display decode: dataIn=16'h0004 -> pos=13; an=2'b01 gives seg=1001111; an=2'b10 gives seg=0000110; an toggles every 4 cycles.
REQ-029 SHALL test dot falling off: dataIn 16'h0001 then 16'h0000 -> pos holds 15; valid=0 two edges after the 0 input; moved=0; both slots seg=1111110.
REQ-030 SHALL test multi-hot and hold:
- dataIn=16'h0011 -> valid=0, dash shown.
- dataIn=16'h0400 held 10 cycles -> pos=5, one moved pulse only.
REQ-031 SHALL test the macro with pos=5, tens slot: seg=1111111 when DOT_POS_DISPLAY_BLANK_LEAD_EN is defined, seg=0000001 when it is not.
